// File: rtl/led_event_blinker.sv
`default_nettype none
// ============================================================================
// Module   : led_event_blinker
// Purpose  : Turns single-cycle event pulses into visible LED blinks. Each
//            event yields ON_CYCLES of led high followed by OFF_CYCLES of led
//            low. Events that arrive while a blink is in progress are counted
//            in a saturating pending counter and replayed back-to-back.
// Ports    : clk      - system clock, all state on posedge
//            rst      - asynchronous active-high reset
//            event_in - one-cycle event pulse
//            clr_ovf  - clears the sticky overflow flag
//            led      - blink output (registered)
//            busy     - high while a blink (ON or OFF phase) is running
//            pending  - queued events not yet started
//            overflow - sticky: an event was dropped on a saturated queue
// Revision : 1.0 - initial release
// ============================================================================
module led_event_blinker #(
    parameter int ON_CYCLES  = 8,
    parameter int OFF_CYCLES = 8,
    parameter int TMR_W      = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             event_in,
    input  logic             clr_ovf,
    output logic             led,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    // Timer counts down to zero, so load value is cycles-1.
    localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0] OFF_LOAD = TMR_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_next;
    logic [CNT_W-1:0] pending_next;
    logic             overflow_next;
    logic             off_end;
    logic             start;
    logic             accept;
    logic             drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            timer    <= '0;
            led      <= 1'b0;
            busy     <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            timer    <= timer_next;
            led      <= (state_next == ST_ON);
            busy     <= (state_next != ST_IDLE);
            pending  <= pending_next;
            overflow <= overflow_next;
        end
    end

    always_comb begin
        state_next    = state;
        timer_next    = timer;
        pending_next  = pending;
        overflow_next = overflow;

        // Last cycle of the OFF phase: either chain straight into the next
        // blink (queued or coincident event) or fall back to idle.
        off_end = (state == ST_OFF) && (timer == '0);
        start   = off_end && ((pending != '0) || event_in);
        // In IDLE the event starts the blink directly and is never queued.
        accept  = event_in && (state != ST_IDLE);
        drop    = accept && !start && (pending == PEND_MAX);

        case (state)
            ST_IDLE: begin
                if (event_in) begin
                    state_next = ST_ON;
                    timer_next = ON_LOAD;
                end
            end
            ST_ON: begin
                if (timer != '0) begin
                    timer_next = timer - TMR_W'(1);
                end else begin
                    state_next = ST_OFF;
                    timer_next = OFF_LOAD;
                end
            end
            ST_OFF: begin
                if (timer != '0) begin
                    timer_next = timer - TMR_W'(1);
                end else if (start) begin
                    state_next = ST_ON;
                    timer_next = ON_LOAD;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                timer_next = '0;
            end
        endcase

        // Accept and consume in the same cycle cancel out.
        if (accept && !start) begin
            if (pending != PEND_MAX) begin
                pending_next = pending + CNT_W'(1);
            end
        end else if (!accept && start) begin
            if (pending != '0) begin
                pending_next = pending - CNT_W'(1);
            end
        end

        // A drop in the same cycle as a clear must leave the flag set.
        if (drop) begin
            overflow_next = 1'b1;
        end else if (clr_ovf) begin
            overflow_next = 1'b0;
        end
    end

endmodule
`default_nettype wire
